uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serial transmitter.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1 frame).
// Reset is synchronous and active-low; all state changes on posedge clk.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high; pops the FIFO head into the shift register if any
// START  | start bit (txd low) for CLKS_PER_BIT cycles
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// PARITY | even parity over the data byte (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (txd high) for CLKS_PER_BIT cycles, then IDLE
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   DEPTH_C   = FIFO_DEPTH[PW:0];
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic          txd_nxt;
    logic          push;
    logic          pop;
    logic          baud_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
    logic          parity_nxt;
`endif

    // Handshake and status decode from registered state only.
    assign tx_ready = (fifo_count < DEPTH_C);
    assign push     = tx_valid && tx_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign baud_end = (baud_cnt == BAUD_LAST);

    // FIFO storage; contents need no reset since count/pointers gate reads.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers wrap naturally at the power-of-two depth; push+pop keeps count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath updates and the line level for the next cycle.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        bit_nxt    = bit_idx;
        shreg_nxt  = shreg;
        txd_nxt    = 1'b1;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt = parity_q;
`endif
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    shreg_nxt  = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    parity_nxt = ^mem[rd_ptr];
`endif
                    baud_nxt   = '0;
                    bit_nxt    = '0;
                    state_nxt  = START;
                end
            end
            START: begin
                txd_nxt = 1'b0;
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                txd_nxt = shreg[0];
                if (baud_end) begin
                    baud_nxt  = '0;
                    shreg_nxt = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd_nxt = parity_q;
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = STOP;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                txd_nxt = 1'b1;
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers; txd is registered so no input reaches it combinationally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shreg    <= shreg_nxt;
            txd      <= txd_nxt;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// Accepted bytes are queued at the handshake; a line receiver pops and compares.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int starts_q[$];

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .resetn(resetn),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .txd(txd),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard push on every accepted byte.
    always @(posedge clk) begin
        if (resetn && tx_valid && tx_ready) exp_q.push_back(tx_data);
    end

    // Line receiver: samples one cycle into each bit and checks against the queue.
    always begin
        logic [7:0] rx;
        logic       rx_start;
        logic       rx_stop;
        logic [7:0] e;
`ifdef UART_TX_PARITY_EN
        logic       rx_par;
`endif
        @(negedge clk);
        if (mon_en && resetn && txd === 1'b0) begin
            starts_q.push_back(cyc);
            @(negedge clk);
            rx_start = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rx[i] = txd;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            rx_par = txd;
`endif
            repeat (CPB) @(negedge clk);
            rx_stop = txd;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected got frame %h required none", rx);
            end else begin
                e = exp_q.pop_front();
                if (rx !== e) begin
                    failures++;
                    $display("FAIL rx_data got %h required %h", rx, e);
                end
                checks++;
                if (rx_start !== 1'b0 || rx_stop !== 1'b1) begin
                    failures++;
                    $display("FAIL rx_framing got start=%b stop=%b required 0/1", rx_start, rx_stop);
                end
`ifdef UART_TX_PARITY_EN
                checks++;
                if (rx_par !== ^e) begin
                    failures++;
                    $display("FAIL rx_parity got %b required %b", rx_par, ^e);
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles after the push edge of byte b from idle.
    function automatic logic exp_txd(input logic [7:0] b, input int k);
        int slot;
        if (k < 2) return 1'b1;
        slot = (k - 2) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout got busy=%b required 0 within %0d cycles", busy, limit);
        end
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset;
        resetn   = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        repeat (3) tick();
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got %b required 1", txd); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d required 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b required 1", tx_ready); end
        tx_valid = 1'b0;
        resetn   = 1'b1;
        repeat (3) tick();
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_push_discard got %0d required 0", fifo_count); end
        checks++; if (txd !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_idle got txd=%b busy=%b required 1/0", txd, busy); end
    endtask

    task automatic test_frame(input logic [7:0] b);
        logic e;
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1 || busy !== 1'b1) begin failures++; $display("FAIL frame_push got count=%0d busy=%b required 1/1", fifo_count, busy); end
        for (int k = 1; k <= FB*CPB + 1; k++) begin
            tick();
            e = exp_txd(b, k);
            checks++;
            if (txd !== e) begin
                failures++;
                $display("FAIL frame_txd byte=%h k=%0d got %b required %b", b, k, txd, e);
            end
            if (k == 1) begin
                checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL frame_pop got %0d required 0", fifo_count); end
            end
            if (k == FB*CPB) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frame_busy_end got %b required 1", busy); end
            end
            if (k == FB*CPB + 1) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_busy_fall got %b required 0", busy); end
            end
        end
        wait_idle(20);
    endtask

    task automatic test_fill_overflow;
        int exp_cnt[5] = '{1, 1, 2, 3, 4};
        int p = FB*CPB + 2;
        starts_q.delete();
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        for (int k = 0; k <= 4; k++) begin
            tick();
            checks++;
            if (fifo_count !== 3'(exp_cnt[k])) begin
                failures++;
                $display("FAIL fill_count k=%0d got %0d required %0d", k, fifo_count, exp_cnt[k]);
            end
            tx_data = (k < 4) ? 8'(k + 2) : 8'h06;
        end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_full got %b required 0", tx_ready); end
        for (int k = 5; k <= p + 1; k++) begin
            tick();
            if (k == p - 1) begin
                checks++; if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin failures++; $display("FAIL fill_stall got count=%0d ready=%b required 4/0", fifo_count, tx_ready); end
            end
            if (k == p) begin
                checks++; if (fifo_count !== 3'd3 || tx_ready !== 1'b1) begin failures++; $display("FAIL fill_after_pop got count=%0d ready=%b required 3/1", fifo_count, tx_ready); end
            end
            if (k == p + 1) begin
                checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fill_late_accept got %0d required 4", fifo_count); end
            end
        end
        tx_valid = 1'b0;
        wait_idle(600);
        checks++;
        if (starts_q.size() != 6) begin
            failures++;
            $display("FAIL fill_frames got %0d required 6", starts_q.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (starts_q[i] - starts_q[i-1] != FB*CPB + 1) begin
                    failures++;
                    $display("FAIL fill_gap i=%0d got %0d required %0d", i, starts_q[i] - starts_q[i-1], FB*CPB + 1);
                end
            end
        end
    endtask

    task automatic test_simul_push_pop;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick();
        tx_data  = 8'hC3;
        tick();
        tx_data  = 8'h81;
        tick();
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_setup got %0d required 2", fifo_count); end
        repeat (FB*CPB - 1) tick();
        checks++; if (fifo_count !== 3'd2 || tx_ready !== 1'b1) begin failures++; $display("FAIL simul_before got count=%0d ready=%b required 2/1", fifo_count, tx_ready); end
        tx_valid = 1'b1;
        tx_data  = 8'h7E;
        tick();
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_count got %0d required 2", fifo_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL simul_busy got %b required 1", busy); end
        wait_idle(400);
    endtask

    task automatic test_reset_mid_frame;
        int low_cnt = 0;
        int busy_cnt = 0;
        mon_en   = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_data  = 8'h11;
        tick();
        tx_data  = 8'h22;
        tick();
        tx_valid = 1'b0;
        repeat (16) tick();
        checks++; if (txd !== 1'b0 || fifo_count !== 3'd2) begin failures++; $display("FAIL abort_setup got txd=%b count=%0d required 0/2", txd, fifo_count); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL abort_txd got %b required 1", txd); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL abort_count got %0d required 0", fifo_count); end
        checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got busy=%b ready=%b required 0/1", busy, tx_ready); end
        for (int k = 0; k < 100; k++) begin
            tick();
            if (txd !== 1'b1) low_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        checks++; if (low_cnt != 0 || busy_cnt != 0) begin failures++; $display("FAIL abort_quiet got low=%0d busy=%0d required 0/0", low_cnt, busy_cnt); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_frame(8'h55);
        test_frame(8'h07);
        test_frame(8'h03);
        test_frame(8'hFE);
        test_fill_overflow();
        test_simul_push_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
